// File: rtl/preliminary_pkg.sv
// Shared widths, limits and pipeline control bundle for the preliminary-processing chain.
package preliminary_pkg;
  localparam int ADC_W   = 16;
  localparam int LO_W    = 18;
  localparam int PROD_W  = ADC_W + LO_W;
  localparam int ACC_W   = 40;
  localparam int OUT_W   = 32;
  localparam int CNT_W   = 8;
  localparam int SHIFT_W = 4;

  localparam longint OUT_MAX = (64'sd1 <<< (OUT_W - 1)) - 64'sd1;
  localparam longint OUT_MIN = -(64'sd1 <<< (OUT_W - 1));

  // Per-sample control that travels alongside the data through the pipeline.
  typedef struct packed {
    logic               load;
    logic               latch;
    logic               use_smp;
    logic               exceeds;
    logic [SHIFT_W-1:0] shift;
  } ctl_t;
endpackage

// File: rtl/tbt_demod_mac.sv
// Registered multiply (stage 2) and turn accumulator (stage 3) for one LO component.
module tbt_demod_mac #(
  parameter int ADC_WIDTH  = 16,
  parameter int LO_WIDTH   = 18,
  parameter int PROD_WIDTH = 34,
  parameter int ACC_WIDTH  = 40
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ADC_WIDTH-1:0] adc_i,
  input  logic [LO_WIDTH-1:0]  lo_i,
  input  logic                 use_i,
  input  logic                 load_i,
  output logic [ACC_WIDTH-1:0] acc_o
);
  logic signed [PROD_WIDTH-1:0] prod_d, prod_q;
  logic signed [ACC_WIDTH-1:0]  acc_d, acc_q;

  always_comb begin
    prod_d = '0;
    if (use_i) prod_d = PROD_WIDTH'($signed(adc_i)) * PROD_WIDTH'($signed(lo_i));
  end

  // load_i is aligned with prod_q, so a load starts the turn with this product.
  always_comb begin
    acc_d = acc_q + ACC_WIDTH'(prod_q);
    if (load_i) acc_d = ACC_WIDTH'(prod_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prod_q <= '0;
      acc_q  <= '0;
    end else begin
      prod_q <= prod_d;
      acc_q  <= acc_d;
    end
  end

  assign acc_o = acc_q;
endmodule

// File: rtl/tbt_demodulator.sv
// Per-ADC synchronous demodulator: I/Q turn-by-turn sums bounded by LO load/latch markers.
module tbt_demodulator
  import preliminary_pkg::*;
#(
  parameter int ADC_WIDTH        = ADC_W,
  parameter int LO_WIDTH         = LO_W,
  parameter int SAMPLES_PER_TURN = 77,
  parameter int ACC_WIDTH        = ACC_W,
  parameter int OUTPUT_WIDTH     = OUT_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADC_WIDTH-1:0]    adcData,
  input  logic [LO_WIDTH-1:0]     loCos,
  input  logic [LO_WIDTH-1:0]     loSin,
  input  logic                    tbtLoadAccumulator,
  input  logic                    tbtLatchAccumulator,
  input  logic                    adcUseThisSample,
  input  logic                    adcExceedsThreshold,
  input  logic [SHIFT_W-1:0]      sumShift,
  output logic [OUTPUT_WIDTH-1:0] tbtI,
  output logic [OUTPUT_WIDTH-1:0] tbtQ,
  output logic [CNT_W-1:0]        tbtSampleCount,
  output logic                    tbtExceeded,
  output logic                    tbtValid,
  output logic                    tbtToggle,
  output logic                    tbtOverflow
);
  // Full product width: (-2^15)*(-2^17) = 2^32 needs ADC+LO bits to stay exact.
  localparam int PROD_WIDTH = ADC_WIDTH + LO_WIDTH;
  localparam int CNT_INT_W  = ($clog2(SAMPLES_PER_TURN + 1) > CNT_W) ?
                              $clog2(SAMPLES_PER_TURN + 1) : CNT_W;
  localparam logic [CNT_INT_W-1:0] CNT_SAT = CNT_INT_W'((1 << CNT_W) - 1);
  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
    {{(ACC_WIDTH-OUTPUT_WIDTH+1){1'b0}}, {(OUTPUT_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
    {{(ACC_WIDTH-OUTPUT_WIDTH+1){1'b1}}, {(OUTPUT_WIDTH-1){1'b0}}};

  logic [ADC_WIDTH-1:0] adc_s1_q;
  logic [LO_WIDTH-1:0]  cos_s1_q, sin_s1_q;
  ctl_t                 ctl_s1_q, ctl_s2_q;
  logic                 lat_s3_q;
  logic [SHIFT_W-1:0]   shift_s3_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      adc_s1_q   <= '0;
      cos_s1_q   <= '0;
      sin_s1_q   <= '0;
      ctl_s1_q   <= '0;
      ctl_s2_q   <= '0;
      lat_s3_q   <= 1'b0;
      shift_s3_q <= '0;
    end else begin
      adc_s1_q         <= adcData;
      cos_s1_q         <= loCos;
      sin_s1_q         <= loSin;
      ctl_s1_q.load    <= tbtLoadAccumulator;
      ctl_s1_q.latch   <= tbtLatchAccumulator;
      ctl_s1_q.use_smp <= adcUseThisSample;
      ctl_s1_q.exceeds <= adcExceedsThreshold;
      ctl_s1_q.shift   <= sumShift;
      ctl_s2_q         <= ctl_s1_q;
      lat_s3_q         <= ctl_s2_q.latch;
      shift_s3_q       <= ctl_s2_q.shift;
    end
  end

  logic [ACC_WIDTH-1:0] acc_i, acc_q;

  tbt_demod_mac #(
    .ADC_WIDTH (ADC_WIDTH),
    .LO_WIDTH  (LO_WIDTH),
    .PROD_WIDTH(PROD_WIDTH),
    .ACC_WIDTH (ACC_WIDTH)
  ) u_mac_cos (
    .clk   (clk),
    .rst   (rst),
    .adc_i (adc_s1_q),
    .lo_i  (cos_s1_q),
    .use_i (ctl_s1_q.use_smp),
    .load_i(ctl_s2_q.load),
    .acc_o (acc_i)
  );

  tbt_demod_mac #(
    .ADC_WIDTH (ADC_WIDTH),
    .LO_WIDTH  (LO_WIDTH),
    .PROD_WIDTH(PROD_WIDTH),
    .ACC_WIDTH (ACC_WIDTH)
  ) u_mac_sin (
    .clk   (clk),
    .rst   (rst),
    .adc_i (adc_s1_q),
    .lo_i  (sin_s1_q),
    .use_i (ctl_s1_q.use_smp),
    .load_i(ctl_s2_q.load),
    .acc_o (acc_q)
  );

  logic [CNT_INT_W-1:0] cnt_d, cnt_q;
  logic                 exc_d, exc_q;
  logic                 hit;

  always_comb begin
    hit   = ctl_s2_q.use_smp & ctl_s2_q.exceeds;
    cnt_d = cnt_q;
    exc_d = exc_q | hit;
    if (ctl_s2_q.load) begin
      cnt_d = CNT_INT_W'(ctl_s2_q.use_smp);
      exc_d = hit;
    end else if (ctl_s2_q.use_smp && cnt_q < CNT_SAT) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  logic [ACC_WIDTH-1:0] cap_i_q, cap_q_q;
  logic [CNT_INT_W-1:0] cap_cnt_q;
  logic                 cap_exc_q, cap_vld_q;
  logic [SHIFT_W-1:0]   cap_shift_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q       <= '0;
      exc_q       <= 1'b0;
      cap_i_q     <= '0;
      cap_q_q     <= '0;
      cap_cnt_q   <= '0;
      cap_exc_q   <= 1'b0;
      cap_shift_q <= '0;
      cap_vld_q   <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      exc_q     <= exc_d;
      cap_vld_q <= lat_s3_q;
      if (lat_s3_q) begin
        cap_i_q     <= acc_i;
        cap_q_q     <= acc_q;
        cap_cnt_q   <= cnt_q;
        cap_exc_q   <= exc_q;
        cap_shift_q <= shift_s3_q;
      end
    end
  end

  // Returns {overflow, clamped value}.
  function automatic logic [OUTPUT_WIDTH:0] scale(input logic [ACC_WIDTH-1:0] a,
                                                  input logic [SHIFT_W-1:0] sh);
    logic signed [ACC_WIDTH-1:0] s;
    s = $signed(a) >>> sh;
    if (s > SAT_MAX)      scale = {1'b1, SAT_MAX[OUTPUT_WIDTH-1:0]};
    else if (s < SAT_MIN) scale = {1'b1, SAT_MIN[OUTPUT_WIDTH-1:0]};
    else                  scale = {1'b0, s[OUTPUT_WIDTH-1:0]};
  endfunction

  logic [OUTPUT_WIDTH:0] sc_i, sc_q;
  always_comb begin
    sc_i = scale(cap_i_q, cap_shift_q);
    sc_q = scale(cap_q_q, cap_shift_q);
  end

  logic [OUTPUT_WIDTH-1:0] tbt_i_q, tbt_q_q;
  logic [CNT_W-1:0]        tbt_cnt_q;
  logic                    tbt_exc_q, tbt_vld_q, tbt_tog_q, tbt_ovf_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tbt_i_q   <= '0;
      tbt_q_q   <= '0;
      tbt_cnt_q <= '0;
      tbt_exc_q <= 1'b0;
      tbt_vld_q <= 1'b0;
      tbt_tog_q <= 1'b0;
      tbt_ovf_q <= 1'b0;
    end else begin
      tbt_vld_q <= cap_vld_q;
      if (cap_vld_q) begin
        tbt_i_q   <= sc_i[OUTPUT_WIDTH-1:0];
        tbt_q_q   <= sc_q[OUTPUT_WIDTH-1:0];
        tbt_ovf_q <= sc_i[OUTPUT_WIDTH] | sc_q[OUTPUT_WIDTH];
        tbt_cnt_q <= cap_cnt_q[CNT_W-1:0];
        tbt_exc_q <= cap_exc_q;
        tbt_tog_q <= ~tbt_tog_q;
      end
    end
  end

  assign tbtI           = tbt_i_q;
  assign tbtQ           = tbt_q_q;
  assign tbtSampleCount = tbt_cnt_q;
  assign tbtExceeded    = tbt_exc_q;
  assign tbtValid       = tbt_vld_q;
  assign tbtToggle      = tbt_tog_q;
  assign tbtOverflow    = tbt_ovf_q;
endmodule
